reg_bank_5x3: RTL and testbench
===============================

Name: reg_bank_5x3

Overview:
Five-entry, 3-bit register bank with a single write port. It sits directly upstream of the 5:1 one-hot read selector and drives that selector's five option inputs and its 5-bit one-hot choice. The choice comes either from a binary read address or from an internal scan pointer that steps through the entries automatically.

Parameters:
WIDTH, 3, data width of each entry and of wdata/regN outputs
NUM_REGS, 5, number of entries (fixed at 5; addresses 0..4 valid)
SCAN_DIV, 4, clock cycles per scan-pointer step; legal range >= 1

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
we  input  1  write enable
waddr  input  3  binary write address
wdata  input  WIDTH  write data
raddr  input  3  binary read address, used when scan_en=0
scan_en  input  1  1 = choice follows the internal scan pointer
reg0..reg4  output  WIDTH each  current entry contents (to option0..option4)
choice  output  5  registered one-hot read select (to selector choice)
ptr  output  3  current scan pointer value, 0..4
waddr_err  output  1  one-cycle pulse on a write to an illegal address

Behaviour:
- Reset: one clock domain (clk). rst is asynchronous and active-high. While rst=1, all of the following are forced immediately, independent of clk:
  - reg0..reg4 = 0
  - choice = 5'b00000
  - ptr = 0
  - scan divider count = 0
  - waddr_err = 0
- Reset mid-operation: a write in progress is discarded. The first active edge after rst falls behaves like a normal cycle.
- Write: on a rising edge with we=1 and waddr<=4, entry[waddr] <= wdata. regN shows the new value after that edge (one-cycle latency). Other entries hold.
- Illegal write: we=1 with waddr in 5..7 → no entry changes; waddr_err=1 for exactly the following cycle.
  - Back-to-back illegal writes hold waddr_err high for each such cycle.
  - we=0 → waddr_err=0 next cycle.
- Read select, scan_en=0: choice <= one-hot(raddr), i.e. bit raddr set, on each rising edge; latency 1 cycle.
  - raddr in 5..7 → choice <= 5'b00000.
- Read select, scan_en=1: choice <= one-hot(ptr) on each rising edge.
- Scan divider:
  - While scan_en=1, the count increments each cycle.
  - When count == SCAN_DIV-1, count <= 0 and ptr <= ptr+1, wrapping 4→0 (never 5..7).
  - While scan_en=0, count <= 0 and ptr holds its value.
  - Re-enabling scan therefore resumes from the held ptr with a full SCAN_DIV period.
- Simultaneous write and read of the same entry: choice selection is unaffected; the data change appears on regN in the same cycle choice updates. No bypass logic.
- choice is always one-hot or all-zero; it is never multi-hot.
- Arithmetic: ptr and count are unsigned and wrap only as stated. WIDTH-bit data is stored unmodified.

Test Plan:
- Reset then idle: assert rst asynchronously mid-cycle → reg0..reg4=0, choice=00000, ptr=0, waddr_err=0 immediately, with no clock edge required.
- Writes: we=1, waddr=0..4, wdata=1,2,3,4,5 on successive cycles → after 5 edges reg0=1, reg1=2, reg2=3, reg3=4, reg4=5. waddr=6, wdata=7 next → all entries unchanged, waddr_err=1 for one cycle only.
- Direct read: scan_en=0, raddr=3 → choice=01000 one edge later. raddr=7 → choice=00000.
- Scan: SCAN_DIV=4, scan_en=1 from reset → ptr steps 0,1,2,3,4,0 every 4 cycles. choice follows one cycle behind: 00001, 00010, …, 10000, 00001.
- Scan pause/resume: drop scan_en at ptr=2 for 10 cycles → ptr stays 2. Re-assert → ptr=3 after exactly 4 cycles.
- Reset mid-write: pulse rst for a partial cycle while we=1, waddr=1, wdata=6 → reg1=0 afterwards. A normal write on the next edge succeeds.

Source files
------------

// File: rtl/reg_bank_5x3.sv
// reg_bank_5x3: five-entry, WIDTH-bit register bank with one write port.
// Drives the downstream 5:1 one-hot selector: reg0..reg4 feed its option
// inputs and choice feeds its one-hot select. choice comes from either the
// binary read address or an internal scan pointer stepped every SCAN_DIV
// cycles. There is no handshake here: every input is sampled on every edge.
module reg_bank_5x3 #(
  parameter int WIDTH    = 3,
  parameter int NUM_REGS = 5,
  parameter int SCAN_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       raddr,
  input  logic             scan_en,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic [WIDTH-1:0] reg2,
  output logic [WIDTH-1:0] reg3,
  output logic [WIDTH-1:0] reg4,
  output logic [4:0]       choice,
  output logic [2:0]       ptr,
  output logic             waddr_err
);

  // A single-cycle scan period still needs a one-bit counter that stays at 0.
  localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [2:0]       LAST_ADDR = 3'(NUM_REGS - 1);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [4:0]       choice_q, choice_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             waddr_err_q, waddr_err_d;
  logic [2:0]       sel_addr;

  // Write port: update the addressed entry; flag addresses beyond the last entry.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we && (waddr == 3'(i))) begin
        regs_d[i] = wdata;
      end
    end
    waddr_err_d = we && (waddr > LAST_ADDR);
  end

  // Scan divider: step the pointer once per SCAN_DIV enabled cycles, 4 wraps to 0.
  // Disabling scan clears the count so a resume always gets a full period.
  always_comb begin
    cnt_d = '0;
    ptr_d = ptr_q;
    if (scan_en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        ptr_d = (ptr_q == LAST_ADDR) ? 3'd0 : ptr_q + 3'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Read select: decode the chosen address to one-hot; out-of-range decodes to zero.
  always_comb begin
    sel_addr = scan_en ? ptr_q : raddr;
    choice_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_addr == 3'(i)) begin
        choice_d[i] = 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      choice_q    <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      waddr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      choice_q    <= choice_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      waddr_err_q <= waddr_err_d;
    end
  end

  assign reg0      = regs_q[0];
  assign reg1      = regs_q[1];
  assign reg2      = regs_q[2];
  assign reg3      = regs_q[3];
  assign reg4      = regs_q[4];
  assign choice    = choice_q;
  assign ptr       = ptr_q;
  assign waddr_err = waddr_err_q;

endmodule

// File: tb/tb_reg_bank_5x3.sv
// Directed bench for reg_bank_5x3 with hand-computed expectations.
module tb_reg_bank_5x3;

  logic       clk;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [2:0] wdata;
  logic [2:0] raddr;
  logic       scan_en;
  logic [2:0] reg0, reg1, reg2, reg3, reg4;
  logic [4:0] choice;
  logic [2:0] ptr;
  logic       waddr_err;

  int passed_cnt = 0;
  int total_cnt  = 0;

  reg_bank_5x3 #(.WIDTH(3), .NUM_REGS(5), .SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .scan_en  (scan_en),
    .reg0     (reg0),
    .reg1     (reg1),
    .reg2     (reg2),
    .reg3     (reg3),
    .reg4     (reg4),
    .choice   (choice),
    .ptr      (ptr),
    .waddr_err(waddr_err)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) passed_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_regs(input string tag, input logic [2:0] e0, input logic [2:0] e1,
                            input logic [2:0] e2, input logic [2:0] e3, input logic [2:0] e4);
    check({tag, "_reg0"}, 8'(reg0), 8'(e0));
    check({tag, "_reg1"}, 8'(reg1), 8'(e1));
    check({tag, "_reg2"}, 8'(reg2), 8'(e2));
    check({tag, "_reg3"}, 8'(reg3), 8'(e3));
    check({tag, "_reg4"}, 8'(reg4), 8'(e4));
  endtask

  // One active edge, then sample 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_ptr;
    logic [4:0] exp_choice;
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; scan_en = 1'b0;

    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    check_regs("rst_async", 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    check("rst_async_choice", 8'(choice), 8'h00);
    check("rst_async_ptr", 8'(ptr), 8'h00);
    check("rst_async_err", 8'(waddr_err), 8'h00);
    #4 rst = 1'b0;                   // t=7, after the edge at 5
    tick();                          // idle cycle
    check_regs("idle", 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    check("idle_choice", 8'(choice), 8'h01);   // raddr=0 selects entry 0

    // Writes 1..5 into entries 0..4
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 3'(i + 1);
      tick();
    end
    check_regs("wr", 3'd1, 3'd2, 3'd3, 3'd4, 3'd5);
    check("wr_err", 8'(waddr_err), 8'h00);

    // Illegal writes: 6, then 5 back-to-back, then idle
    we = 1'b1; waddr = 3'd6; wdata = 3'd7;
    tick();
    check("ill6_err", 8'(waddr_err), 8'h01);
    check_regs("ill6", 3'd1, 3'd2, 3'd3, 3'd4, 3'd5);
    waddr = 3'd5; wdata = 3'd6;
    tick();
    check("ill5_err", 8'(waddr_err), 8'h01);
    check_regs("ill5", 3'd1, 3'd2, 3'd3, 3'd4, 3'd5);
    we = 1'b0;
    tick();
    check("ill_clear_err", 8'(waddr_err), 8'h00);
    we = 1'b1; waddr = 3'd7; wdata = 3'd3;
    tick();
    check("ill7_err", 8'(waddr_err), 8'h01);
    we = 1'b0;
    tick();
    check("ill7_clear_err", 8'(waddr_err), 8'h00);
    check_regs("ill7", 3'd1, 3'd2, 3'd3, 3'd4, 3'd5);

    // Direct read select
    raddr = 3'd3;
    tick();
    check("rd3_choice", 8'(choice), 8'h08);
    raddr = 3'd7;
    tick();
    check("rd7_choice", 8'(choice), 8'h00);
    raddr = 3'd5;
    tick();
    check("rd5_choice", 8'(choice), 8'h00);
    raddr = 3'd4;
    tick();
    check("rd4_choice", 8'(choice), 8'h10);
    // Same-entry write and read: both land on the same edge
    we = 1'b1; waddr = 3'd4; wdata = 3'd2; raddr = 3'd4;
    tick();
    check("rdwr_choice", 8'(choice), 8'h10);
    check_regs("rdwr", 3'd1, 3'd2, 3'd3, 3'd4, 3'd2);
    we = 1'b0;

    // Scan from a zero pointer and zero count (scan has been off since reset)
    scan_en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp_ptr    = 3'((k / 4) % 5);
      exp_choice = 5'(1 << (((k - 1) / 4) % 5));
      check($sformatf("scan_ptr_k%0d", k), 8'(ptr), 8'(exp_ptr));
      check($sformatf("scan_choice_k%0d", k), 8'(choice), 8'(exp_choice));
    end
    // Now ptr=2 with two cycles of count accumulated; pause for 10 cycles
    scan_en = 1'b0; raddr = 3'd1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("pause_ptr_k%0d", k), 8'(ptr), 8'h02);
      check($sformatf("pause_choice_k%0d", k), 8'(choice), 8'h02);
    end
    // Resume: full period before the next step
    scan_en = 1'b1;
    tick();
    check("resume1_ptr", 8'(ptr), 8'h02);
    check("resume1_choice", 8'(choice), 8'h04);
    tick();
    check("resume2_ptr", 8'(ptr), 8'h02);
    tick();
    check("resume3_ptr", 8'(ptr), 8'h02);
    tick();
    check("resume4_ptr", 8'(ptr), 8'h03);
    check("resume4_choice", 8'(choice), 8'h04);

    // Reset mid-write, with waddr_err and choice nonzero beforehand
    scan_en = 1'b0; raddr = 3'd0; we = 1'b1; waddr = 3'd6; wdata = 3'd1;
    tick();
    check("pre_rst_err", 8'(waddr_err), 8'h01);
    check("pre_rst_choice", 8'(choice), 8'h01);
    waddr = 3'd1; wdata = 3'd6;
    #2 rst = 1'b1;                   // mid-cycle, no edge
    #1;
    check_regs("rst_mid", 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
    check("rst_mid_choice", 8'(choice), 8'h00);
    check("rst_mid_ptr", 8'(ptr), 8'h00);
    check("rst_mid_err", 8'(waddr_err), 8'h00);
    #2;
    rst = 1'b0; we = 1'b1; waddr = 3'd2; wdata = 3'd5;
    tick();
    check_regs("post_rst", 3'd0, 3'd0, 3'd5, 3'd0, 3'd0);
    check("post_rst_err", 8'(waddr_err), 8'h00);
    check("post_rst_ptr", 8'(ptr), 8'h00);
    we = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed_cnt, total_cnt);
    $finish;
  end

endmodule
